// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the configurable UART blocks.
//   tx_state_e  - transmitter FSM states
//   parity_e    - parity_mode encoding (2'b11 also means none)
//   DBITS_*     - data_bits encoding (5..8 data bits)
//   IDLE_LVL    - idle/mark level of the serial line
//   data_mask() - payload mask for a data_bits setting
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_ODD  = 2'b01,
        PAR_EVEN = 2'b10
    } parity_e;

    localparam logic [1:0] DBITS_5 = 2'b00;
    localparam logic [1:0] DBITS_6 = 2'b01;
    localparam logic [1:0] DBITS_7 = 2'b10;
    localparam logic [1:0] DBITS_8 = 2'b11;

    localparam logic IDLE_LVL = 1'b1;

    function automatic logic [7:0] data_mask(input logic [1:0] bits);
        return (bits == DBITS_8) ? 8'hFF :
               (bits == DBITS_7) ? 8'h7F :
               (bits == DBITS_6) ? 8'h3F :
               (bits == DBITS_5) ? 8'h1F : 8'h1F;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period timer shared by the UART transmitter and receiver.
//   Clk, Rst_n - clock, asynchronous active-low reset
//   run        - count while a frame is in progress
//   restart    - hold the counter at zero (next bit starts fresh)
//   div        - bit period is div+1 clocks
//   bit_end    - high on the last clock of each bit period
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             run,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic             bit_end
);

    logic [DIV_W-1:0] r_cnt;

    assign bit_end = run && !restart && (r_cnt == div);

    // Wrapping on bit_end makes every following bit start at zero.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            r_cnt <= '0;
        else
            r_cnt <= (restart || bit_end) ? '0 : run ? r_cnt + DIV_W'(1) : r_cnt;
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter with one-entry holding register.
//   Clk, Rst_n   - clock, asynchronous active-low reset
//   Send_en      - write strobe, taken only while Tx_Ready=1
//   data_byte    - payload (bits above the configured width ignored)
//   baud_div     - bit period = baud_div+1 clocks
//   data_bits    - 5..8 data bits; stop_bits - 1 or 2 stop bits
//   parity_mode  - none/odd/even; only honoured when UART_TX_PARITY_EN is defined
//   Rs232_Tx     - registered serial line; Tx_Done - last clock of final stop bit
//   uart_state   - busy; Tx_Ready - holding register empty
// Build option: define UART_TX_PARITY_EN to build the parity bit and PARITY state.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Send_en,
    input  logic [7:0]       data_byte,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [1:0]       data_bits,
    input  logic             stop_bits,
    input  logic [1:0]       parity_mode,
    output logic             Rs232_Tx,
    output logic             Tx_Done,
    output logic             uart_state,
    output logic             Tx_Ready
);

    tx_state_e        r_state, w_state_nxt;
    logic [7:0]       r_shift, w_shift_nxt, r_hold, w_load_data;
    logic             r_hold_v;
    logic [2:0]       r_bit_cnt;
    logic             r_stop_cnt, r_stop2;
    logic [1:0]       r_nbits;
    logic [DIV_W-1:0] r_div;
    logic             r_tx, w_tx_nxt;
    logic             w_bit_end, w_last_data, w_frame_end, w_load, w_hold_wr;
    logic             w_par_en, w_par_bit;

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .run     (r_state != IDLE),
        .restart (r_state == IDLE),
        .div     (r_div),
        .bit_end (w_bit_end)
    );

    // Last data index is N-1 = data_bits+4, i.e. {1, data_bits}.
    assign w_last_data = r_bit_cnt == {1'b1, r_nbits};
    assign w_frame_end = (r_state == STOP) && w_bit_end && (r_stop_cnt == r_stop2);
    // A new frame enters the shifter from IDLE, or straight off the final stop bit
    // from the hold (or from a coincident strobe when the hold is empty).
    assign w_load      = ((r_state == IDLE) && Send_en) || (w_frame_end && (r_hold_v || Send_en));
    assign w_load_data = (r_hold_v ? r_hold : data_byte) & data_mask(data_bits);
    assign w_hold_wr   = Send_en && !r_hold_v && (r_state != IDLE) && !w_frame_end;
    assign w_shift_nxt = w_load ? w_load_data :
                         ((r_state == DATA) && w_bit_end) ? r_shift >> 1 : r_shift;

`ifdef UART_TX_PARITY_EN
    logic r_par_en, r_par_bit;

    // Payload is already masked, so the reduction covers only transmitted bits.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
        end else if (w_load) begin
            r_par_en  <= (parity_mode == PAR_ODD) || (parity_mode == PAR_EVEN);
            r_par_bit <= (^w_load_data) ^ (parity_mode == PAR_ODD);
        end
    end

    assign w_par_en  = r_par_en;
    assign w_par_bit = r_par_bit;
`else
    logic w_unused_par;

    assign w_unused_par = ^parity_mode;
    assign w_par_en     = 1'b0;
    assign w_par_bit    = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = Send_en ? START : IDLE;
            START:   w_state_nxt = w_bit_end ? DATA : START;
            DATA:    w_state_nxt = (w_bit_end && w_last_data) ? (w_par_en ? PARITY : STOP) : DATA;
            PARITY:  w_state_nxt = w_bit_end ? STOP : PARITY;
            STOP:    w_state_nxt = w_frame_end ? (w_load ? START : IDLE) : STOP;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Line level is computed from the next state so the registered pin lines up with it.
    always_comb begin
        w_tx_nxt   = (w_state_nxt == START)  ? 1'b0 :
                     (w_state_nxt == DATA)   ? w_shift_nxt[0] :
                     (w_state_nxt == PARITY) ? w_par_bit : IDLE_LVL;
        Tx_Done    = w_frame_end;
        uart_state = r_state != IDLE;
        Tx_Ready   = !r_hold_v;
        Rs232_Tx   = r_tx;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_tx       <= IDLE_LVL;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_nbits    <= '0;
            r_stop2    <= 1'b0;
            r_div      <= '0;
            r_hold     <= '0;
            r_hold_v   <= 1'b0;
        end else begin
            r_tx    <= w_tx_nxt;
            r_shift <= w_shift_nxt;
            if (w_load) begin
                r_nbits    <= data_bits;
                r_stop2    <= stop_bits;
                r_div      <= baud_div;
                r_bit_cnt  <= '0;
                r_stop_cnt <= 1'b0;
            end else begin
                if ((r_state == DATA) && w_bit_end)
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                if ((r_state == STOP) && w_bit_end)
                    r_stop_cnt <= 1'b1;
            end
            if (w_hold_wr) begin
                r_hold   <= data_byte;
                r_hold_v <= 1'b1;
            end else if (w_frame_end && r_hold_v) begin
                r_hold_v <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: self-checking bench for uart_tx_cfg (table, random and corner sequences).
module tb_uart_tx_cfg;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILT = 1'b1;
`else
    localparam bit PAR_BUILT = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst_n, Send_en;
    logic [7:0]  data_byte;
    logic [15:0] baud_div;
    logic [1:0]  data_bits, parity_mode;
    logic        stop_bits;
    logic        Rs232_Tx, Tx_Done, uart_state, Tx_Ready;

    int n_chk = 0;
    int n_fail = 0;

    bit q_line[$], q_ready[$], q_done[$], exp_q[$];

    typedef struct {
        logic [7:0] d;
        int dv, db, sb, pm;
        int len_par, len_np;
    } vec_t;
    vec_t vecs[5];

    uart_tx_cfg #(.DIV_W(16)) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .Send_en     (Send_en),
        .data_byte   (data_byte),
        .baud_div    (baud_div),
        .data_bits   (data_bits),
        .stop_bits   (stop_bits),
        .parity_mode (parity_mode),
        .Rs232_Tx    (Rs232_Tx),
        .Tx_Done     (Tx_Done),
        .uart_state  (uart_state),
        .Tx_Ready    (Tx_Ready)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Record the current clock's outputs while busy, then advance one clock.
    task automatic tick();
        if (uart_state === 1'b1) begin
            q_line.push_back(Rs232_Tx);
            q_ready.push_back(Tx_Ready);
            q_done.push_back(Tx_Done);
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_q();
        q_line.delete();
        q_ready.delete();
        q_done.delete();
        exp_q.delete();
    endtask

    // Reference: list the frame's bits, then repeat each for one bit period.
    task automatic add_frame(input logic [7:0] d, input int dv, input int db, input int sb, input int pm);
        bit bits[$];
        int ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < db + 5; i++) begin
            bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (PAR_BUILT && (pm == 1 || pm == 2))
            bits.push_back(pm == 1 ? (ones % 2 == 0) : (ones % 2 == 1));
        for (int i = 0; i <= sb; i++)
            bits.push_back(1'b1);
        foreach (bits[i])
            repeat (dv + 1) exp_q.push_back(bits[i]);
    endtask

    task automatic set_cfg(input logic [7:0] d, input int dv, input int db, input int sb, input int pm);
        data_byte   = d;
        baud_div    = 16'(dv);
        data_bits   = 2'(db);
        stop_bits   = 1'(sb);
        parity_mode = 2'(pm);
    endtask

    task automatic drain(input string tag);
        int g = 0;
        while (uart_state === 1'b1 && g < 5000) begin
            tick();
            g++;
        end
        check({tag, "_idle_after"}, int'(uart_state), 0);
    endtask

    task automatic cmp_wave(input string tag);
        int bad = -1;
        check({tag, "_len"}, q_line.size(), exp_q.size());
        foreach (exp_q[i])
            if (bad < 0 && (i >= q_line.size() || q_line[i] != exp_q[i]))
                bad = i;
        check({tag, "_first_bad_clk"}, bad, -1);
    endtask

    function automatic int count_done();
        int n = 0;
        foreach (q_done[i]) n += int'(q_done[i]);
        return n;
    endfunction

    function automatic int count_not_ready(input int lo, input int hi);
        int n = 0;
        foreach (q_ready[i]) if (i >= lo && i <= hi && !q_ready[i]) n++;
        return n;
    endfunction

    task automatic run_frame(input logic [7:0] d, input int dv, input int db, input int sb,
                             input int pm, input int exp_len, input string tag);
        int dpos = -1;
        clear_q();
        add_frame(d, dv, db, sb, pm);
        set_cfg(d, dv, db, sb, pm);
        Send_en = 1'b1;
        tick();
        Send_en = 1'b0;
        // Config changes mid-frame must not affect the frame in flight.
        data_byte   = 8'($urandom);
        baud_div    = 16'($urandom_range(0, 7));
        data_bits   = 2'($urandom);
        stop_bits   = 1'($urandom);
        parity_mode = 2'($urandom);
        drain(tag);
        cmp_wave(tag);
        if (exp_len >= 0)
            check({tag, "_table_len"}, q_line.size(), exp_len);
        foreach (q_done[i]) if (q_done[i]) dpos = i;
        check({tag, "_done_cnt"}, count_done(), 1);
        check({tag, "_done_pos"}, dpos, exp_q.size() - 1);
        check({tag, "_ready_low"}, count_not_ready(0, 1 << 20), 0);
        check({tag, "_line_idle"}, int'(Rs232_Tx), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int fired, g;
        Rst_n   = 1'b0;
        Send_en = 1'b0;
        set_cfg(8'h00, 0, 3, 0, 0);
        #12;
        check("rst_tx", int'(Rs232_Tx), 1);
        check("rst_done", int'(Tx_Done), 0);
        check("rst_busy", int'(uart_state), 0);
        check("rst_ready", int'(Tx_Ready), 1);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        tick();
        tick();

        vecs[0] = '{8'h55, 3, 3, 0, 0, 40, 40};
        vecs[1] = '{8'h03, 0, 2, 1, 2, 11, 10};
        vecs[2] = '{8'hFF, 1, 0, 0, 1, 16, 14};
        vecs[3] = '{8'hA5, 2, 3, 1, 3, 33, 33};
        vecs[4] = '{8'h96, 0, 1, 0, 1, 9, 8};
        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].d, vecs[i].dv, vecs[i].db, vecs[i].sb, vecs[i].pm,
                      PAR_BUILT ? vecs[i].len_par : vecs[i].len_np, $sformatf("vec%0d", i));
            tick();
        end

        for (int i = 0; i < 25; i++) begin
            run_frame(8'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), -1,
                      $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 2)) tick();
        end

        // Back-to-back through the hold, with a dropped third strobe.
        clear_q();
        add_frame(8'hA5, 1, 3, 0, 0);
        add_frame(8'h3C, 1, 3, 0, 0);
        set_cfg(8'hA5, 1, 3, 0, 0);
        Send_en = 1'b1;
        tick();
        Send_en = 1'b0;
        repeat (4) tick();
        data_byte = 8'h3C;
        Send_en   = 1'b1;
        tick();
        Send_en = 1'b0;
        check("b2b_ready_after_hold", int'(Tx_Ready), 0);
        data_byte = 8'hFF;
        Send_en   = 1'b1;
        tick();
        Send_en   = 1'b0;
        data_byte = 8'h00;
        drain("b2b");
        cmp_wave("b2b");
        check("b2b_done_cnt", count_done(), 2);
        check("b2b_done_first", q_done.size() > 19 ? int'(q_done[19]) : 0, 1);
        check("b2b_ready_low_span", count_not_ready(0, 1 << 20), 15);
        check("b2b_ready_low_until_load", count_not_ready(5, 19), 15);
        check("b2b_ready_rise", q_ready.size() > 20 ? int'(q_ready[20]) : 0, 1);
        tick();

        // Strobe coincident with Tx_Done while the hold is empty.
        clear_q();
        add_frame(8'h5A, 0, 3, 0, 0);
        add_frame(8'hC3, 0, 3, 0, 0);
        set_cfg(8'h5A, 0, 3, 0, 0);
        Send_en = 1'b1;
        tick();
        Send_en = 1'b0;
        fired = 0;
        g = 0;
        while (uart_state === 1'b1 && g < 200) begin
            if (Tx_Done === 1'b1 && fired == 0) begin
                data_byte = 8'hC3;
                Send_en   = 1'b1;
                fired     = 1;
            end
            tick();
            Send_en = 1'b0;
            g++;
        end
        check("coinc_idle_after", int'(uart_state), 0);
        cmp_wave("coinc");
        check("coinc_done_cnt", count_done(), 2);
        check("coinc_ready_low", count_not_ready(0, 1 << 20), 0);
        tick();

        // Reset pulsed mid-DATA with the hold full.
        clear_q();
        set_cfg(8'hF0, 3, 3, 0, 0);
        Send_en = 1'b1;
        tick();
        Send_en = 1'b0;
        repeat (10) tick();
        data_byte = 8'h11;
        Send_en   = 1'b1;
        tick();
        Send_en = 1'b0;
        check("rst_pre_ready", int'(Tx_Ready), 0);
        repeat (3) tick();
        check("rst_pre_line", int'(Rs232_Tx), 0);
        Rst_n = 1'b0;
        #2;
        check("rst_mid_tx", int'(Rs232_Tx), 1);
        check("rst_mid_busy", int'(uart_state), 0);
        check("rst_mid_ready", int'(Tx_Ready), 1);
        check("rst_mid_done", int'(Tx_Done), 0);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        repeat (6) tick();
        check("rst_hold_discarded", int'(uart_state), 0);
        check("rst_line_idle", int'(Rs232_Tx), 1);
        run_frame(8'hC9, 2, 3, 0, 0, 30, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
